// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, logical/arithmetic shifts, rotates,
// parallel load and clear. It also counts shifts and pulses word_done
// once for every WIDTH shifts.
module univ_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic [2:0]                   mode,
    input  logic                         din,
    input  logic [WIDTH-1:0]             pdata,
    output logic [WIDTH-1:0]             a,
    output logic                         sout_msb,
    output logic                         sout_lsb,
    output logic [$clog2(WIDTH+1)-1:0]   shift_cnt,
    output logic                         word_done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    localparam logic [2:0] M_HOLD  = 3'b000;
    localparam logic [2:0] M_SHR   = 3'b001;
    localparam logic [2:0] M_SHL   = 3'b010;
    localparam logic [2:0] M_ROR   = 3'b011;
    localparam logic [2:0] M_ROL   = 3'b100;
    localparam logic [2:0] M_LOAD  = 3'b101;
    localparam logic [2:0] M_ASR   = 3'b110;
    localparam logic [2:0] M_CLEAR = 3'b111;

    logic [WIDTH-1:0] a_reg, a_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             done_reg, done_next;
    logic             is_shift;

    // Next-state decode. word_done defaults low, so it can only be a single-cycle pulse.
    always_comb begin
        a_next    = a_reg;
        cnt_next  = cnt_reg;
        done_next = 1'b0;
        is_shift  = 1'b0;
        if (en) begin
            case (mode)
                M_HOLD:  a_next = a_reg;
                M_SHR:   begin a_next = {din, a_reg[WIDTH-1:1]};            is_shift = 1'b1; end
                M_SHL:   begin a_next = {a_reg[WIDTH-2:0], din};            is_shift = 1'b1; end
                M_ROR:   begin a_next = {a_reg[0], a_reg[WIDTH-1:1]};       is_shift = 1'b1; end
                M_ROL:   begin a_next = {a_reg[WIDTH-2:0], a_reg[WIDTH-1]}; is_shift = 1'b1; end
                M_LOAD:  begin a_next = pdata;                              cnt_next = '0; end
                M_ASR:   begin a_next = {a_reg[WIDTH-1], a_reg[WIDTH-1:1]}; is_shift = 1'b1; end
                M_CLEAR: begin a_next = '0;                                 cnt_next = '0; end
                default: a_next = a_reg;
            endcase
            // The shift that would complete a word wraps the count and fires the pulse.
            if (is_shift) begin
                if (cnt_reg == LAST_CNT) begin
                    cnt_next  = '0;
                    done_next = 1'b1;
                end else begin
                    cnt_next  = cnt_reg + 1'b1;
                end
            end
        end
    end

    // State flops. Reset clears everything at once and also drops any partial word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_reg    <= '0;
            cnt_reg  <= '0;
            done_reg <= 1'b0;
        end else begin
            a_reg    <= a_next;
            cnt_reg  <= cnt_next;
            done_reg <= done_next;
        end
    end

    assign a         = a_reg;
    assign sout_msb  = a_reg[WIDTH-1];
    assign sout_lsb  = a_reg[0];
    assign shift_cnt = cnt_reg;
    assign word_done = done_reg;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg. An 8-bit instance is checked against a reference
// model through an expected-result queue. A 16-bit instance is checked with
// directed constants.
module tb_univ_shift_reg;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        en8 = 1'b0, din8 = 1'b0;
    logic [2:0]  mode8 = 3'b000;
    logic [7:0]  pdata8 = 8'h00;
    logic [7:0]  a8;
    logic        msb8, lsb8, done8;
    logic [3:0]  cnt8;

    logic        en16 = 1'b0, din16 = 1'b0;
    logic [2:0]  mode16 = 3'b000;
    logic [15:0] pdata16 = 16'h0000;
    logic [15:0] a16;
    logic        msb16, lsb16, done16;
    logic [4:0]  cnt16;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] a;
        logic [3:0] cnt;
        logic       done;
    } exp_t;
    exp_t exp_q[$];

    logic [7:0] m_a;
    int         m_cnt;
    logic       m_done;

    univ_shift_reg #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .en(en8), .mode(mode8), .din(din8),
        .pdata(pdata8), .a(a8), .sout_msb(msb8), .sout_lsb(lsb8),
        .shift_cnt(cnt8), .word_done(done8)
    );

    univ_shift_reg #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .en(en16), .mode(mode16), .din(din16),
        .pdata(pdata16), .a(a16), .sout_msb(msb16), .sout_lsb(lsb16),
        .shift_cnt(cnt16), .word_done(done16)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic [2:0] m, input logic d, input logic e, input logic [7:0] p);
        logic sh;
        sh = 1'b0;
        m_done = 1'b0;
        if (e) begin
            case (m)
                3'b001: begin m_a = {d, m_a[7:1]};       sh = 1'b1; end
                3'b010: begin m_a = {m_a[6:0], d};       sh = 1'b1; end
                3'b011: begin m_a = {m_a[0], m_a[7:1]};  sh = 1'b1; end
                3'b100: begin m_a = {m_a[6:0], m_a[7]};  sh = 1'b1; end
                3'b101: begin m_a = p;    m_cnt = 0; end
                3'b110: begin m_a = {m_a[7], m_a[7:1]};  sh = 1'b1; end
                3'b111: begin m_a = 8'h00; m_cnt = 0; end
                default: ;
            endcase
            if (sh) begin
                if (m_cnt == 7) begin m_cnt = 0; m_done = 1'b1; end
                else m_cnt = m_cnt + 1;
            end
        end
    endtask

    // Drive one operation on the 8-bit DUT, push the expected result, then pop it after the edge and compare.
    task automatic op8(input logic [2:0] m, input logic d, input logic e, input logic [7:0] p);
        exp_t x;
        @(negedge clk);
        mode8 = m; din8 = d; en8 = e; pdata8 = p;
        model_step(m, d, e, p);
        exp_q.push_back('{a: m_a, cnt: 4'(m_cnt), done: m_done});
        @(posedge clk);
        #1;
        x = exp_q.pop_front();
        $display("op8 mode=%b din=%b en=%b pdata=%h -> a=%h cnt=%0d done=%b", m, d, e, p, a8, cnt8, done8);
        chk("a8", a8, x.a);
        chk("cnt8", cnt8, x.cnt);
        chk("done8", done8, x.done);
        chk("msb8", msb8, x.a[7]);
        chk("lsb8", lsb8, x.a[0]);
    endtask

    task automatic op16(input logic [2:0] m, input logic d, input logic [15:0] p);
        @(negedge clk);
        mode16 = m; din16 = d; en16 = 1'b1; pdata16 = p;
        @(posedge clk);
        #1;
        $display("op16 mode=%b din=%b pdata=%h -> a=%h cnt=%0d done=%b", m, d, p, a16, cnt16, done16);
    endtask

    // Assert reset between edges, check that it takes effect before the next edge and that a clock edge during reset changes nothing.
    task automatic async_rst();
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        $display("async reset asserted -> a8=%h cnt8=%0d done8=%b", a8, cnt8, done8);
        chk("rst_a8", a8, 8'h00);
        chk("rst_cnt8", cnt8, 4'd0);
        chk("rst_done8", done8, 1'b0);
        en8 = 1'b1; mode8 = 3'b101; pdata8 = 8'hFF;
        @(posedge clk);
        #1;
        chk("rst_hold_a8", a8, 8'h00);
        en8 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        m_a = 8'h00; m_cnt = 0; m_done = 1'b0;
    endtask

    initial begin
        m_a = 8'h00; m_cnt = 0; m_done = 1'b0;
        #2;
        chk("por_a8", a8, 8'h00);
        chk("por_cnt8", cnt8, 4'd0);
        chk("por_done8", done8, 1'b0);
        chk("por_a16", a16, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Shift-left fill with din=1 produces 01, 03, ... FF. The pulse follows edge 8 only.
        for (int i = 0; i < 8; i++) begin
            op8(3'b010, 1'b1, 1'b1, 8'h00);
            chk("fill_a", a8, 8'((16'h1 << (i + 1)) - 1));
            chk("fill_done", done8, (i == 7));
        end
        op8(3'b000, 1'b0, 1'b1, 8'h00);
        chk("hold_done", done8, 1'b0);

        // Rotate right of A5 gives D2. Eight rotates return A5 with a pulse.
        op8(3'b101, 1'b0, 1'b1, 8'hA5);
        op8(3'b011, 1'b0, 1'b1, 8'h00);
        chk("ror1", a8, 8'hD2);
        for (int i = 0; i < 7; i++) op8(3'b011, 1'b0, 1'b1, 8'h00);
        chk("ror8", a8, 8'hA5);
        chk("ror8_done", done8, 1'b1);

        // Arithmetic shift right replicates the MSB.
        op8(3'b101, 1'b0, 1'b1, 8'h96);
        op8(3'b110, 1'b0, 1'b1, 8'h00);
        chk("asr1", a8, 8'hCB);
        op8(3'b110, 1'b0, 1'b1, 8'h00);
        chk("asr2", a8, 8'hE5);

        // A disabled clock enable freezes the count. A later load restarts the word.
        op8(3'b101, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 5; i++) op8(3'b010, 1'b1, 1'b1, 8'h00);
        for (int i = 0; i < 3; i++) op8(3'b010, 1'b0, 1'b0, 8'h00);
        chk("en_frz_cnt", cnt8, 4'd5);
        chk("en_frz_a", a8, 8'h1F);
        op8(3'b101, 1'b0, 1'b1, 8'h00);
        chk("load_cnt0", cnt8, 4'd0);
        for (int i = 0; i < 8; i++) op8(3'b100, 1'b0, 1'b1, 8'h00);

        // Shift-right drain moves the bit from the MSB to the LSB.
        op8(3'b101, 1'b0, 1'b1, 8'h80);
        for (int i = 0; i < 7; i++) op8(3'b001, 1'b0, 1'b1, 8'h00);
        chk("shr_drain", a8, 8'h01);

        // Consecutive words: two words of rotate-left give pulses with no gap cycle.
        op8(3'b001, 1'b1, 1'b1, 8'h00);
        for (int i = 0; i < 16; i++) op8(3'b100, 1'b0, 1'b1, 8'h00);
        op8(3'b111, 1'b0, 1'b1, 8'h00);
        chk("clear_a", a8, 8'h00);

        // Async reset with a=3C, then a reset mid-word that must discard the partial count.
        op8(3'b101, 1'b0, 1'b1, 8'h3C);
        async_rst();
        for (int i = 0; i < 3; i++) op8(3'b010, 1'b1, 1'b1, 8'h00);
        async_rst();
        for (int i = 0; i < 8; i++) op8(3'b010, 1'b0, 1'b1, 8'h00);

        // WIDTH=16: load FFFF, then 16 left shifts with din=0 give 0000 and one pulse.
        op16(3'b101, 1'b0, 16'hFFFF);
        chk("w16_load", a16, 16'hFFFF);
        for (int i = 0; i < 16; i++) begin
            op16(3'b010, 1'b0, 16'h0000);
            chk("w16_a", a16, 16'(32'hFFFF << (i + 1)));
            chk("w16_done", done16, (i == 15));
        end
        op16(3'b000, 1'b0, 16'h0000);
        chk("w16_after", done16, 1'b0);
        chk("w16_cnt", cnt16, 5'd0);

        chk("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter: WIDTH, default 8, register width in bits; legal range 2..64.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: en  input  1  clock enable; when low, all state holds.
REQ-005 Port: mode  input  3  operation select, encoding per REQ-011.
REQ-006 Port: din  input  1  serial data in; enters LSB on shift-left and MSB on shift-right.
REQ-007 Port: pdata  input  WIDTH  parallel load data.
REQ-008 Port: a  output  WIDTH  register contents, driven directly from the state flops.
REQ-009 Port: sout_msb, sout_lsb  output  1 each  continuous copies of a[WIDTH-1] and a[0].
REQ-010 Port: shift_cnt  output  clog2(WIDTH+1)  shifts completed in the current word; word_done  output  1  one-cycle word-complete pulse.

Function
REQ-011 The block SHALL decode mode as follows:
- 000: hold.
- 001: shift right, din to MSB.
- 010: shift left, din to LSB.
- 011: rotate right, a[0] to MSB.
- 100: rotate left, a[WIDTH-1] to LSB.
- 101: parallel load pdata.
- 110: arithmetic shift right, MSB replicated.
- 111: synchronous clear to 0.
REQ-012 All updates SHALL occur on the rising clk edge only when en=1; en=0 freezes a and shift_cnt and forces word_done low on the next edge.
REQ-013 Shift/rotate modes (001, 010, 011, 100, 110) with en=1 SHALL each increment shift_cnt by 1.
REQ-014 The edge on which shift_cnt would reach WIDTH SHALL instead set shift_cnt to 0 and assert word_done for exactly the following cycle (registered pulse).
REQ-015 word_done SHALL be 0 on every other edge, including consecutive-word boundaries; back-to-back words SHALL give one pulse every WIDTH shifts with no gap cycle.
REQ-016 Load (101) and clear (111) SHALL set shift_cnt to 0 and word_done to 0, regardless of the current count.
REQ-017 Hold (000) SHALL leave a and shift_cnt unchanged and drive word_done to 0.
REQ-018 Latency: a reflects the operation one edge after mode/en/din/pdata are sampled; no combinational path from inputs to a, shift_cnt or word_done.
REQ-019 No mode SHALL produce X or out-of-range shift_cnt; shift_cnt SHALL never exceed WIDTH-1.

Reset
REQ-020 reset=1 SHALL immediately, without a clock edge, force a=0, shift_cnt=0, word_done=0.
REQ-021 While reset=1, clk edges SHALL have no effect.
REQ-022 After reset deasserts, operation SHALL resume on the first rising clk edge.
REQ-023 Reset asserted mid-word SHALL discard the partial count, and no word_done pulse SHALL be issued for that word.

Verification (WIDTH=8 unless stated)
REQ-024 Async reset: assert reset between clk edges with a=0x3C -> a=0x00, shift_cnt=0, word_done=0 before the next edge.
REQ-025 Shift-left fill: after reset, mode=010, din=1, en=1 for 8 edges -> a=01,03,07,...,FF; word_done=1 only in the cycle after edge 8; shift_cnt returns to 0.
REQ-026 Rotate and ASR:
- Load 0xA5, then mode=011 -> D2 after 1 edge; A5 after 8 edges, with word_done pulse.
- Load 0x96, then mode=110 twice -> CB, then E5.
REQ-027 Enable and mid-word load:
- 5 shifts, en=0 for 3 edges -> a and shift_cnt=5 frozen.
- Then load 0x00 -> shift_cnt=0; next word_done only after 8 further shifts.
REQ-028 Shift-right drain and WIDTH=16:
- WIDTH=8: load 0x80, mode=001, din=0 for 7 edges -> a=0x01.
- WIDTH=16: load 0xFFFF, shift-left din=0 for 16 edges -> a=0x0000, single word_done.
